// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the cacheline arbiter between the I/D caches and memory.
package cacheline_arbiter_pkg;

  // Default cacheline width in bits.
  localparam int unsigned LINE_W = 256;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  // Owner of the most recent grant; used for round-robin on conflict.
  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/cacheline_arbiter.sv
// Two-to-one cacheline port arbiter: serializes I-cache fills and D-cache
// fills/write-backs onto one memory port, round-robin on conflict, with the
// winning request latched for the whole memory transaction.
module cacheline_arbiter #(
  parameter int unsigned LINE_W = cacheline_arbiter_pkg::LINE_W,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // D-cache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // Memory side
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_address,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp
);
  import cacheline_arbiter_pkg::*;

  arb_state_t        state_q, state_d;
  arb_owner_t        last_q, last_d;
  logic              m_read_d, m_write_d;
  logic [ADDR_W-1:0] m_address_d;
  logic [LINE_W-1:0] m_wdata_d;
  logic              i_req, d_req;
  logic              grant_i, grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Next-state: arbitration in IDLE, completion on m_resp while busy.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    m_read_d    = m_read;
    m_write_d   = m_write;
    m_address_d = m_address;
    m_wdata_d   = m_wdata;
    grant_i     = 1'b0;
    grant_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          // Conflict: the side that did not win last time goes first.
          if (last_q == ARB_I) grant_d = 1'b1;
          else                 grant_i = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end

        if (grant_i) begin
          state_d     = I_BUSY;
          last_d      = ARB_I;
          m_read_d    = 1'b1;
          m_write_d   = 1'b0;
          m_address_d = i_address;
        end else if (grant_d) begin
          state_d     = D_BUSY;
          last_d      = ARB_D;
          // Read and write together is illegal; the write wins.
          m_write_d   = d_write;
          m_read_d    = ~d_write;
          m_address_d = d_address;
          m_wdata_d   = d_wdata;
        end
      end

      I_BUSY, D_BUSY: begin
        if (m_resp) begin
          state_d   = IDLE;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        m_read_d  = 1'b0;
        m_write_d = 1'b0;
      end
    endcase
  end

  // State, grant history and the latched memory request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= ARB_I;
      m_read    <= 1'b0;
      m_write   <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      m_read    <= m_read_d;
      m_write   <= m_write_d;
      m_address <= m_address_d;
      m_wdata   <= m_wdata_d;
    end
  end

  // Outputs: zero-latency response routing to the current owner only.
  always_comb begin
    i_rdata = m_rdata;
    d_rdata = m_rdata;
    i_resp  = (state_q == I_BUSY) && m_resp;
    d_resp  = (state_q == D_BUSY) && m_resp;
  end

  // The D-cache must never request a read and a write-back at once.
  illegal_d_rw: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write))
    else $error("cacheline_arbiter: d_read and d_write asserted together");

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed scoreboard bench for cacheline_arbiter.
module tb_cacheline_arbiter;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              m_read;
  logic              m_write;
  logic [ADDR_W-1:0] m_address;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_rdata;
  logic              m_resp;

  cacheline_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_resp(m_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic              is_d;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
  } txn_t;

  txn_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic req_i(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] rd);
    txn_t t;
    i_read    = 1'b1;
    i_address = a;
    t.is_d = 1'b0; t.wr = 1'b0; t.addr = a; t.wdata = '0; t.rdata = rd;
    sb.push_back(t);
  endtask

  task automatic req_d(input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] wd, input logic [LINE_W-1:0] rd);
    txn_t t;
    d_read    = ~wr;
    d_write   = wr;
    d_address = a;
    d_wdata   = wd;
    t.is_d = 1'b1; t.wr = wr; t.addr = a; t.wdata = wd; t.rdata = rd;
    sb.push_back(t);
  endtask

  // Step until the memory port shows a request, then compare it with the head.
  task automatic await_grant(output int waited);
    txn_t e;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!(m_read || m_write) && waited < 12);
    chk1("grant_seen", m_read | m_write, 1'b1);
    e = sb[0];
    chka("grant_addr", m_address, e.addr);
    chk1("grant_write", m_write, e.wr);
    chk1("grant_read", m_read, ~e.wr);
    if (e.wr) chkd("grant_wdata", m_wdata, e.wdata);
  endtask

  // Hold for wait_cyc busy cycles, respond, then the owner drops its request.
  task automatic finish_txn(input int unsigned wait_cyc, output logic owner_d);
    txn_t e;
    e = sb.pop_front();
    owner_d = e.is_d;
    for (int unsigned k = 0; k < wait_cyc; k++) begin
      chk1("hold_read", m_read, ~e.wr);
      chk1("hold_write", m_write, e.wr);
      chka("hold_addr", m_address, e.addr);
      chk1("early_i_resp", i_resp, 1'b0);
      chk1("early_d_resp", d_resp, 1'b0);
      step();
    end
    m_resp  = 1'b1;
    m_rdata = e.rdata;
    #1;
    chka("resp_addr", m_address, e.addr);
    chk1("resp_i", i_resp, ~e.is_d);
    chk1("resp_d", d_resp, e.is_d);
    chkd("resp_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
    step();
    m_resp  = 1'b0;
    m_rdata = '0;
    if (e.is_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
    #1;
    chk1("after_read", m_read, 1'b0);
    chk1("after_write", m_write, 1'b0);
    chk1("after_i_resp", i_resp, 1'b0);
    chk1("after_d_resp", d_resp, 1'b0);
  endtask

  initial begin
    int   w;
    logic od;
    logic [LINE_W-1:0] pat_a, pat_b;

    rst = 1'b1; i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    m_rdata = '0; m_resp = 1'b0;
    pat_a = rnd_line();
    pat_b = rnd_line();
    step();
    step();
    chk1("rst_m_read", m_read, 1'b0);
    chk1("rst_m_write", m_write, 1'b0);
    chka("rst_m_address", m_address, '0);
    chkd("rst_m_wdata", m_wdata, '0);
    chk1("rst_i_resp", i_resp, 1'b0);
    chk1("rst_d_resp", d_resp, 1'b0);
    rst = 1'b0;
    step();

    // I-only read, memory answers in the 4th busy cycle.
    req_i(32'h0000_1040, pat_a);
    await_grant(w);
    chka("i_only_latency", ADDR_W'(w), 32'd1);
    finish_txn(3, od);

    // D write-back.
    req_d(1'b1, 32'h8000_0020, pat_b, rnd_line());
    await_grant(w);
    finish_txn(2, od);

    // D read; requester changes its address while the transaction runs.
    req_d(1'b0, 32'h0000_0200, pat_b, rnd_line());
    await_grant(w);
    d_address = 32'h0000_0300;
    finish_txn(3, od);

    // Reset two cycles into an I transaction, then a stray memory response.
    req_i(32'h0000_5000, rnd_line());
    await_grant(w);
    step();
    rst    = 1'b1;
    i_read = 1'b0;
    step();
    chk1("midrst_m_read", m_read, 1'b0);
    chk1("midrst_m_write", m_write, 1'b0);
    chka("midrst_m_address", m_address, '0);
    chkd("midrst_m_wdata", m_wdata, '0);
    chk1("midrst_i_resp", i_resp, 1'b0);
    rst     = 1'b0;
    m_resp  = 1'b1;
    m_rdata = '1;
    #1;
    chk1("stray_i_resp", i_resp, 1'b0);
    chk1("stray_d_resp", d_resp, 1'b0);
    step();
    m_resp  = 1'b0;
    m_rdata = '0;
    chk1("stray_m_read", m_read, 1'b0);
    chk1("stray_m_write", m_write, 1'b0);
    void'(sb.pop_front());

    // Conflict out of reset: D first, then I after one idle cycle while D
    // re-requests, then D again.
    req_d(1'b0, 32'h0000_0200, '0, rnd_line());
    req_i(32'h0000_0100, rnd_line());
    await_grant(w);
    finish_txn(1, od);
    req_d(1'b0, 32'h0000_0280, '0, rnd_line());
    await_grant(w);
    chka("conflict_gap", ADDR_W'(w), 32'd1);
    finish_txn(1, od);
    await_grant(w);
    finish_txn(0, od);

    // Zero-wait memory with both caches requesting continuously.
    req_i(32'h0000_1000, rnd_line());
    req_d(1'b0, 32'h0000_9000, '0, rnd_line());
    for (int n = 0; n < 20; n++) begin
      await_grant(w);
      chka("stream_gap", ADDR_W'(w), 32'd1);
      finish_txn(0, od);
      if (n < 18) begin
        if (od) req_d(1'b0, 32'h0000_9000 + ADDR_W'((n + 1) * 64), '0, rnd_line());
        else    req_i(32'h0000_1000 + ADDR_W'((n + 1) * 64), rnd_line());
      end
    end
    chka("sb_drained", ADDR_W'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

Two-port-to-one arbiter sharing the single physical-memory (or L2) cacheline port between the instruction cache (read-only) and the data cache (read/write). It sits between the I/D caches and main memory, below the pipeline. It serializes line fills and write-backs with a three-state FSM and round-robin priority on conflict. It latches the winning request for the duration of the memory transaction.

## Interface
- `LINE_W`, default 256: cacheline width in bits.
- `ADDR_W`, default 32: line address width; low 5 bits are passed through unchanged.

- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_read`  in  1  I-cache line read request; held until `i_resp`.
- `i_address`  in  ADDR_W  I-cache line address.
- `i_rdata`  out  LINE_W  line returned to I-cache.
- `i_resp`  out  1  one-cycle completion pulse to I-cache.
- `d_read` / `d_write`  in  1 each  D-cache line read / write-back request; held until `d_resp`.
- `d_address`  in  ADDR_W  D-cache line address.
- `d_wdata`  in  LINE_W  write-back line.
- `d_rdata`  out  LINE_W  line returned to D-cache.
- `d_resp`  out  1  one-cycle completion pulse to D-cache.
- `m_read` / `m_write`  out  1 each  memory-side request, held until `m_resp`.
- `m_address`  out  ADDR_W  latched address.
- `m_wdata`  out  LINE_W  latched write data.
- `m_rdata`  in  LINE_W  memory read data, valid with `m_resp`.
- `m_resp`  in  1  memory completion pulse.

## Operation
- FSM states: `IDLE`, `I_BUSY`, `D_BUSY`.
- `IDLE`, no request: stay.
- `IDLE`, only I request: latch `i_address`, set `m_read`, go to `I_BUSY`.
- `IDLE`, only D request: latch `d_address`/`d_wdata` and the read/write kind, go to `D_BUSY`.
- `IDLE`, both requesting: grant the side opposite `last_grant`.
- `last_grant` is a 1-bit register. It is updated on every grant and reset to I, so D wins the first conflict.
- `I_BUSY` / `D_BUSY`:
  - Hold `m_*` outputs constant.
  - On `m_resp`, forward `m_rdata` to the owner's `*_rdata` and pulse the owner's `*_resp` in the same cycle.
  - Clear `m_read`/`m_write` and return to `IDLE`.
- Non-owner `*_resp` is always 0. `*_rdata` may show `m_rdata` unconditionally; a cache consumes it only with its resp.
- Requests arriving while busy wait; requesters hold them until their own resp.
- `d_read` and `d_write` both high is illegal.
  - Simulation assertion fires.
  - RTL treats it as a write.
- `m_address`/`m_wdata` are registered at grant. Requester inputs changing mid-transaction have no effect.
- `m_resp` outside a busy state is ignored.
- Reset values: state `IDLE`, `last_grant`=I, `m_read`=`m_write`=0, `m_address`=0, `m_wdata`=0, `i_resp`=`d_resp`=0.

## Timing
- A request sampled high in `IDLE` at edge t drives `m_read`/`m_write` high from t+1 (registered outputs). Arbitration overhead is 1 cycle.
- Response path is combinational: `*_resp` is asserted in the same cycle as `m_resp`, with 0 added latency.
- After `m_resp`, the FSM is in `IDLE` for exactly 1 cycle before the next grant.
  - This prevents re-granting a request the cache still shows in its resp cycle.
  - Back-to-back transactions are therefore spaced by at least 1 idle cycle on the `m_*` port.
- `rst` asserted mid-transaction:
  - Abandon the transaction next edge.
  - All outputs go to reset values; no resp is issued.
  - The memory side is reset by the same `rst`.
- A memory response with 0 wait (`m_resp` in the first busy cycle) is legal and completes correctly.

## Structure
- Add enum `arb_state_t {IDLE, I_BUSY, D_BUSY}` and `arb_owner_t {ARB_I, ARB_D}` to the shared types package alongside the processor types.
- Add cacheline width constant `LINE_W` to the same package.
- Single module, no sub-module; the FSM plus request latch is one process pair (next-state comb, state/latch ff).

## Test plan
- I-only read of 0x0000_1040, memory resp after 3 cycles returning pattern A:
  - `m_read` high cycles t+1..t+4, `m_address`=0x0000_1040.
  - `i_resp` pulses 1 cycle with `i_rdata`=A; `d_resp` stays 0.
- D write-back to 0x8000_0020 with `d_wdata`=B:
  - `m_write` high, `m_wdata`=B.
  - `d_resp` pulses on `m_resp`; `m_read` never asserts.
- Simultaneous I read 0x100 and D read 0x200 out of reset:
  - D granted first, then I granted after 1 idle cycle.
  - Next simultaneous conflict grants I first (round-robin).
- Requester changes `d_address` from 0x200 to 0x300 mid-transaction: `m_address` stays 0x200 until resp.
- `rst` asserted 2 cycles into an I transaction, then stray `m_resp`:
  - All outputs 0 the next cycle, no `i_resp`, FSM stays `IDLE`.
- 0-wait memory (`m_resp` on first busy cycle), continuous I and D requests for 20 transactions:
  - Strict I/D alternation.
  - Exactly one resp per transaction.
  - Idle gap of 1 cycle between transactions.
